// File: rtl/div_ctrl.sv
// Sequencing controller between the EX stage and the iterative divider.
// Build option DIV_ZERO_FAST_EN: zero divisors are answered without launching the divider.
module div_ctrl #(
  parameter int WIDTH    = 32,
  parameter int WAIT_MAX = 40
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic             req_signed,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             flush,
  output logic             stall,
  output logic             req_ack,
  output logic             hilo_we,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             err,
  output logic             div_rst,
  output logic             div_en,
  output logic             div_signed,
  output logic [WIDTH-1:0] div_a,
  output logic [WIDTH-1:0] div_b,
  input  logic             div_busy,
  input  logic             div_done,
  input  logic [WIDTH-1:0] div_q,
  input  logic [WIDTH-1:0] div_r
);

  // state  | meaning
  // IDLE   | waiting for a divide request
  // LAUNCH | operands latched, div_en pulsed
  // WAIT   | divider running, result wanted
  // DRAIN  | request killed, discard the in-flight result
  // DONE   | write HI/LO and retire the request
  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT, S_DRAIN, S_DONE} state_t;

  localparam int CW = $clog2(WAIT_MAX + 1);

  state_t        state, state_nxt;
  logic [CW-1:0] wdog_cnt;
  logic          wdog_hit;
  logic          start;
  logic          zero_div;
  logic          zero_fast;
  logic          cap;

`ifdef DIV_ZERO_FAST_EN
  assign zero_div = (op_b == '0);
`else
  assign zero_div = 1'b0;
`endif

  assign wdog_hit = (wdog_cnt == CW'(WAIT_MAX - 1));
  assign stall    = req_valid & ~req_ack;
  assign div_rst  = ~rst;

  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ack   = 1'b0;
    hilo_we   = 1'b0;
    err       = 1'b0;
    div_en    = 1'b0;
    start     = 1'b0;
    zero_fast = 1'b0;
    cap       = 1'b0;
    case (state)
      S_IDLE: begin
        if (req_valid && !flush) begin
          if (zero_div) begin
            zero_fast = 1'b1;
            state_nxt = S_DONE;
          end else if (!div_busy && !div_done) begin
            start     = 1'b1;
            state_nxt = S_LAUNCH;
          end
        end
      end
      S_LAUNCH: begin
        div_en    = ~div_busy & ~div_done;
        state_nxt = flush ? S_DRAIN : S_WAIT;
      end
      S_WAIT: begin
        // A valid result beats the watchdog; a flush with the result drops it.
        if (div_done) begin
          if (flush) begin
            state_nxt = S_IDLE;
          end else begin
            cap       = 1'b1;
            state_nxt = S_DONE;
          end
        end else if (wdog_hit) begin
          err       = 1'b1;
          req_ack   = ~flush;
          state_nxt = S_IDLE;
        end else if (flush) begin
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (div_done) begin
          state_nxt = S_IDLE;
        end else if (wdog_hit) begin
          err       = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_DONE: begin
        hilo_we   = ~flush;
        req_ack   = ~flush;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wdog_cnt <= '0;
    end else if (state == S_LAUNCH) begin
      wdog_cnt <= '0;
    end else if ((state == S_WAIT || state == S_DRAIN) && !wdog_hit) begin
      wdog_cnt <= wdog_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      hi         <= '0;
      lo         <= '0;
      div_a      <= '0;
      div_b      <= '0;
      div_signed <= 1'b0;
    end else begin
      if (start) begin
        div_a      <= op_a;
        div_b      <= op_b;
        div_signed <= req_signed;
      end
      if (zero_fast) begin
        hi <= op_a;
        lo <= '1;
      end
      if (cap) begin
        hi <= div_r;
        lo <= div_q;
      end
    end
  end

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl with a behavioural 34-cycle divider model.
// Expected HI/LO results are queued at request time and popped on hilo_we.
module tb_div_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_signed = 1'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        flush = 1'b0;
  logic        stall, req_ack, hilo_we, err, div_rst, div_en, div_signed;
  logic [31:0] hi, lo, div_a, div_b;
  logic        div_busy = 1'b0;
  logic        div_done = 1'b0;
  logic [31:0] div_q = '0;
  logic [31:0] div_r = '0;
  logic [5:0]  dcnt = '0;
  logic        tie_low = 1'b0;

  typedef struct packed {logic [31:0] hi; logic [31:0] lo;} exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int en_cnt = 0, en_cyc = -1;
  int we_cnt = 0, err_cnt = 0, err_cyc = -1;

  div_ctrl #(.WIDTH(32), .WAIT_MAX(40)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_signed(req_signed),
    .op_a(op_a), .op_b(op_b), .flush(flush), .stall(stall), .req_ack(req_ack),
    .hilo_we(hilo_we), .hi(hi), .lo(lo), .err(err), .div_rst(div_rst),
    .div_en(div_en), .div_signed(div_signed), .div_a(div_a), .div_b(div_b),
    .div_busy(div_busy), .div_done(div_done), .div_q(div_q), .div_r(div_r)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Divider stand-in: div_done rises 34 cycles after the div_en cycle.
  always @(posedge clk) begin
    if (div_rst) begin
      div_busy <= 1'b0;
      div_done <= 1'b0;
      dcnt     <= '0;
    end else if (div_en) begin
      div_busy <= 1'b1;
      div_done <= 1'b0;
      dcnt     <= 6'd33;
      if (div_b == '0) begin
        div_q <= '1;
        div_r <= div_a;
      end else if (div_signed) begin
        div_q <= 32'($signed(div_a) / $signed(div_b));
        div_r <= 32'($signed(div_a) % $signed(div_b));
      end else begin
        div_q <= div_a / div_b;
        div_r <= div_a % div_b;
      end
    end else if (div_busy) begin
      if (dcnt == 6'd1) begin
        div_busy <= 1'b0;
        div_done <= ~tie_low;
      end
      dcnt <= dcnt - 6'd1;
    end else begin
      div_done <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (div_en) begin
      en_cnt++;
      en_cyc = cyc;
      if (div_busy || div_done) chk("en_interlock", 64'(1), 64'(0));
    end
    if (err) begin
      err_cnt++;
      err_cyc = cyc;
    end
    if (hilo_we) begin
      we_cnt++;
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_we", 64'(1), 64'(0));
      end else begin
        e = exp_q.pop_front();
        chk("sb_hi", 64'(hi), 64'(e.hi));
        chk("sb_lo", 64'(lo), 64'(e.lo));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input int limit, output int ack_c, output int stall_c);
    ack_c = -1;
    stall_c = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (req_ack) begin
        ack_c = cyc;
        break;
      end
      if (stall) stall_c++;
    end
    if (ack_c < 0) chk("ack_timeout", 64'(0), 64'(1));
  endtask

  task automatic run_req(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                         input int exp_lat, input int exp_en);
    int n, ack_c, st_c, en0;
    en0 = en_cnt;
    exp_q.push_back(exp_t'{exp_hi, exp_lo});
    req_valid = 1'b1; op_a = a; op_b = b; req_signed = sgn;
    n = cyc;
    wait_ack(120, ack_c, st_c);
    chk("ack_latency", 64'(ack_c - n), 64'(exp_lat));
    chk("stall_cycles", 64'(st_c), 64'(exp_lat));
    tick();
    req_valid = 1'b0;
    chk("en_pulses", 64'(en_cnt - en0), 64'(exp_en));
  endtask

  task automatic chk_reset(input string p);
    chk({p, "_hi"}, 64'(hi), 64'(0));
    chk({p, "_lo"}, 64'(lo), 64'(0));
    chk({p, "_div_a"}, 64'(div_a), 64'(0));
    chk({p, "_div_b"}, 64'(div_b), 64'(0));
    chk({p, "_div_signed"}, 64'(div_signed), 64'(0));
    chk({p, "_strobes"}, 64'({req_ack, hilo_we, err, div_en}), 64'(0));
    chk({p, "_div_rst"}, 64'(div_rst), 64'(1));
  endtask

  initial begin
    int n, ack_c, st_c, en0, we0, e0;

    repeat (3) tick();
    @(negedge clk);
    chk_reset("rst0");
    chk("rst0_stall", 64'(stall), 64'(0));
    tick();
    rst = 1'b1;
    tick();
    chk("run_div_rst", 64'(div_rst), 64'(0));

    // DIVU 100/7 and DIV -100/7
    run_req(32'd100, 32'd7, 1'b0, 32'd2, 32'd14, 36, 1);
    run_req(32'hFFFFFF9C, 32'd7, 1'b1, 32'hFFFFFFFE, 32'hFFFFFFF2, 36, 1);

    // Flush 10 cycles after LAUNCH, new request raised during DRAIN
    en0 = en_cnt; we0 = we_cnt;
    req_valid = 1'b1; op_a = 32'd1000; op_b = 32'd3; req_signed = 1'b0;
    n = cyc;
    repeat (11) tick();
    flush = 1'b1; req_valid = 1'b0;
    tick();
    flush = 1'b0;
    repeat (8) tick();
    chk("drain_hi_kept", 64'(hi), 64'(32'hFFFFFFFE));
    chk("drain_lo_kept", 64'(lo), 64'(32'hFFFFFFF2));
    exp_q.push_back(exp_t'{32'd0, 32'd15});
    req_valid = 1'b1; op_a = 32'd60; op_b = 32'd4;
    wait_ack(120, ack_c, st_c);
    chk("drain_ack_cycle", 64'(ack_c - n), 64'(72));
    tick();
    req_valid = 1'b0;
    chk("drain_relaunch_cycle", 64'(en_cyc - n), 64'(37));
    chk("drain_en_pulses", 64'(en_cnt - en0), 64'(2));
    chk("drain_we_count", 64'(we_cnt - we0), 64'(1));

    // Reset asserted mid-WAIT
    req_valid = 1'b1; op_a = 32'd100; op_b = 32'd7;
    repeat (10) tick();
    rst = 1'b0; req_valid = 1'b0;
    tick();
    @(negedge clk);
    chk_reset("rst_mid");
    tick();
    rst = 1'b1;
    tick();
    run_req(32'd50, 32'd5, 1'b0, 32'd0, 32'd10, 36, 1);

    // Zero divisor
`ifdef DIV_ZERO_FAST_EN
    run_req(32'h1234, 32'd0, 1'b0, 32'h1234, 32'hFFFFFFFF, 1, 0);
`else
    run_req(32'h1234, 32'd0, 1'b0, 32'h1234, 32'hFFFFFFFF, 36, 1);
`endif

    // Watchdog with div_done held low
    tie_low = 1'b1;
    we0 = we_cnt; e0 = err_cnt;
    req_valid = 1'b1; op_a = 32'd77; op_b = 32'd7;
    n = cyc;
    wait_ack(120, ack_c, st_c);
    chk("wd_err_with_ack", 64'(err), 64'(1));
    chk("wd_no_we_with_ack", 64'(hilo_we), 64'(0));
    tick();
    req_valid = 1'b0;
    tie_low = 1'b0;
    chk("wd_ack_after_launch", 64'(ack_c - en_cyc), 64'(40));
    chk("wd_err_after_launch", 64'(err_cyc - en_cyc), 64'(40));
    chk("wd_launch_cycle", 64'(en_cyc - n), 64'(1));
    chk("wd_err_count", 64'(err_cnt - e0), 64'(1));
    chk("wd_we_count", 64'(we_cnt - we0), 64'(0));
    repeat (5) tick();
    chk("wd_err_single", 64'(err_cnt - e0), 64'(1));

    // Back to normal operation after the timeout
    run_req(32'd81, 32'd9, 1'b0, 32'd0, 32'd9, 36, 1);

    chk("sb_drained", 64'(exp_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
- Sequencing controller between the EX stage and the 32-bit iterative divider.
- Accepts DIV/DIVU requests and launches the divider with a one-cycle enable pulse.
- Stalls the pipeline while the divide runs, then writes the quotient/remainder into HI/LO.
- The divider cannot be aborted, so a pipeline flush mid-divide is handled by draining and discarding the in-flight result.

Parameters:
- WIDTH, 32, operand/result width; must equal the divider width.
- WAIT_MAX, 40, watchdog limit in cycles for div_done while in WAIT/DRAIN.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low (0 = reset)
- req_valid  in  1  EX stage holds a divide instruction; held until req_ack
- req_signed  in  1  1 = DIV, 0 = DIVU
- op_a  in  WIDTH  dividend
- op_b  in  WIDTH  divisor
- flush  in  1  pipeline flush/exception; kills the current request
- stall  out  1  pipeline stall request
- req_ack  out  1  one-cycle pulse; request retired
- hilo_we  out  1  one-cycle HI/LO write strobe
- hi  out  WIDTH  remainder
- lo  out  WIDTH  quotient
- err  out  1  one-cycle watchdog-timeout pulse
- div_rst  out  1  divider reset, active-high, = ~rst (combinational)
- div_en  out  1  divider start, one-cycle pulse
- div_signed  out  1  divider hassign
- div_a  out  WIDTH  divider dividend
- div_b  out  WIDTH  divider divisor
- div_busy  in  1  divider busy
- div_done  in  1  divider done; div_q/div_r valid only while high
- div_q  in  WIDTH  divider quotient
- div_r  in  WIDTH  divider remainder

Behaviour:
- Reset (rst=0 at a clk edge):
  - State goes to IDLE.
  - hi, lo, div_a, div_b = 0; div_signed = 0.
  - wdog count = 0.
  - All strobes (req_ack, hilo_we, err, div_en) = 0.
- States: IDLE, LAUNCH, WAIT, DRAIN, DONE.
- IDLE:
  - req_valid & ~flush & ~div_busy: latch op_a→div_a, op_b→div_b, req_signed→div_signed; go to LAUNCH.
  - Otherwise stay in IDLE.
- LAUNCH:
  - div_en=1 for exactly this cycle; wdog count cleared.
  - Next state is DRAIN if flush, else WAIT.
- WAIT:
  - flush → DRAIN.
  - Else div_done → capture div_r→hi and div_q→lo (edge), then go to DONE.
  - Flush and div_done in the same cycle: flush wins; result discarded; go to IDLE directly.
- DRAIN:
  - Waits for div_done, then goes to IDLE.
  - hi/lo are never written.
- DONE:
  - hilo_we=1 and req_ack=1 for this single cycle; then IDLE.
  - flush during DONE suppresses hilo_we and req_ack; the hi/lo registers keep their captured values; go to IDLE.
- Outputs and interlocks:
  - stall = req_valid & ~req_ack (combinational, includes the DRAIN period).
  - div_en is never asserted while div_busy=1 or div_done=1.
- Watchdog: in WAIT or DRAIN the count increments each cycle. On reaching WAIT_MAX:
  - err pulses for one cycle.
  - WAIT path: req_ack pulses, hilo_we does not.
  - Go to IDLE.
- Latency: request seen in IDLE at cycle N → LAUNCH at N+1 → div_done at N+35 → req_ack/hilo_we at N+36.
- A held req_valid after req_ack is a new request only if still high in the next IDLE cycle. Upstream drops req_valid the cycle after req_ack.

Optional Feature:
- Macro: DIV_ZERO_FAST_EN.
- Defined:
  - In IDLE, a request with op_b==0 (and no flush) skips LAUNCH/WAIT.
  - hi←op_a, lo←all ones, then DONE next cycle (req_ack at N+1).
  - Both DIV and DIVU return these values.
  - div_en is not pulsed.
- Undefined: a zero divisor goes through the divider like any other value. Result is whatever the divider produces; for DIVU this is lo=0xFFFFFFFF, hi=op_a.

Test Plan:
- DIVU op_a=100, op_b=7, flush=0:
  - One div_en pulse; stall high N..N+35.
  - N+36: req_ack=1, hilo_we=1, lo=14, hi=2.
- DIV op_a=0xFFFFFF9C (-100), op_b=7: lo=0xFFFFFFF2 (-14), hi=0xFFFFFFFE (-2).
- DIVU 1000/3, flush pulsed 10 cycles after LAUNCH:
  - Enter DRAIN; no hilo_we; hi/lo unchanged.
  - A new request raised during DRAIN launches only after div_done; second result correct.
- rst=0 asserted mid-WAIT:
  - Next cycle: state IDLE, all outputs at reset values, div_rst=1.
  - After release, request 50/5 gives lo=10, hi=0.
- op_b=0, op_a=0x1234 (DIVU): hi=0x1234, lo=0xFFFFFFFF.
  - With DIV_ZERO_FAST_EN: req_ack at N+1, no div_en.
  - Without DIV_ZERO_FAST_EN: req_ack at N+36.
- div_done tied low by bench, WAIT_MAX=40: err and req_ack pulse exactly 40 cycles after LAUNCH; hilo_we stays 0.
